// File: rtl/mpu_load_pkg.sv
`default_nettype none
// ============================================================================
// Module     : mm_defs (package)
// Description: Shared constants, element type and load-FSM state encoding
//              for the MPU load unit.
// Revision   : 1.0 - initial release
// ============================================================================
package mm_defs;

    localparam int CLOCK_PERIOD = 10;
    localparam int FP_BITS      = 32;
    localparam int DEF_MAX_M    = 4;
    localparam int DEF_MAX_N    = 4;

    typedef logic [FP_BITS-1:0] float_sp;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } mpu_load_state_t;

    // Out-of-range dimensions are forced into 1..max_d when checking is off.
    function automatic int unsigned clamp_dim(input int unsigned d, input int unsigned max_d);
        if (d == 0)
            return 1;
        if (d > max_d)
            return max_d;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mpu_load_if.sv
`default_nettype none
// ============================================================================
// Module     : mpu_load_if
// Description: Request, element stream and matrix result bundle of the
//              MPU load unit.
// Revision   : 1.0 - initial release
// ============================================================================
interface mpu_load_if
    import mm_defs::*;
#(
    parameter int DATA_W = FP_BITS,
    parameter int MAX_M  = DEF_MAX_M,
    parameter int MAX_N  = DEF_MAX_N
);

    localparam int M_W = $clog2(MAX_M + 1);
    localparam int N_W = $clog2(MAX_N + 1);

    logic                            load_req_i;
    logic [M_W-1:0]                  load_m_i;
    logic [N_W-1:0]                  load_n_i;
    logic                            load_ready_o;
    logic                            elem_valid_i;
    logic [DATA_W-1:0]               elem_i;
    logic                            elem_ready_o;
    logic [MAX_M*MAX_N*DATA_W-1:0]   matrix_o;
    logic [M_W-1:0]                  m_o;
    logic [N_W-1:0]                  n_o;
    logic                            busy_o;
    logic                            done_o;
    logic                            err_o;

    modport master (
        output load_req_i, load_m_i, load_n_i, elem_valid_i, elem_i,
        input  load_ready_o, elem_ready_o, matrix_o, m_o, n_o, busy_o, done_o, err_o
    );

    modport slave (
        input  load_req_i, load_m_i, load_n_i, elem_valid_i, elem_i,
        output load_ready_o, elem_ready_o, matrix_o, m_o, n_o, busy_o, done_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/mpu_load_addr_gen.sv
`default_nettype none
// ============================================================================
// Module     : mpu_load_addr_gen
// Description: Row-major row/column counters with wrap and last-element flag.
// Revision   : 1.0 - initial release
// ============================================================================
module mpu_load_addr_gen #(
    parameter int M_W   = 3,
    parameter int N_W   = 3,
    parameter int ROW_W = 2,
    parameter int COL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_adv,
    input  logic [M_W-1:0]   i_m,
    input  logic [N_W-1:0]   i_n,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_last
);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_col_last;
    logic             w_row_last;

    assign w_col_last = (32'(r_col) == (32'(i_n) - 32'd1));
    assign w_row_last = (32'(r_row) == (32'(i_m) - 32'd1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_adv) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_col_last && w_row_last;

endmodule
`default_nettype wire

// File: rtl/mpu_load.sv
`default_nettype none
// ============================================================================
// Module     : mpu_load
// Description: MPU load unit - collects a row-major element stream into a
//              parallel matrix register. Optional MPU_LOAD_CHECK_EN rejects
//              out-of-range dimensions instead of clamping them.
// Revision   : 1.0 - initial release
// ============================================================================
module mpu_load
    import mm_defs::*;
#(
    parameter int DATA_W = FP_BITS,
    parameter int MAX_M  = DEF_MAX_M,
    parameter int MAX_N  = DEF_MAX_N
) (
    input  logic        clk,
    input  logic        rst,
    mpu_load_if.slave   bus
);

    localparam int M_W    = $clog2(MAX_M + 1);
    localparam int N_W    = $clog2(MAX_N + 1);
    localparam int ROW_W  = (MAX_M > 1) ? $clog2(MAX_M) : 1;
    localparam int COL_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int N_ELEM = MAX_M * MAX_N;
    localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    mpu_load_state_t r_state;
    mpu_load_state_t w_state_nxt;

    logic              w_load_ready;
    logic              w_elem_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_accept;
    logic              w_xfer;
    logic              w_last;
    logic [M_W-1:0]    w_m_cap;
    logic [N_W-1:0]    w_n_cap;
    logic [M_W-1:0]    r_m;
    logic [N_W-1:0]    r_n;
    logic [ROW_W-1:0]  w_row;
    logic [COL_W-1:0]  w_col;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] r_mat [N_ELEM];

`ifdef MPU_LOAD_CHECK_EN
    logic w_dims_bad;
    logic r_err;

    assign w_dims_bad = (bus.load_m_i == '0) || (bus.load_n_i == '0) ||
                        (32'(bus.load_m_i) > 32'(MAX_M)) || (32'(bus.load_n_i) > 32'(MAX_N));
    assign w_accept   = bus.load_req_i && w_load_ready && !w_dims_bad;
    assign w_m_cap    = bus.load_m_i;
    assign w_n_cap    = bus.load_n_i;

    // A rejected request leaves state and outputs untouched apart from this pulse.
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else
            r_err <= bus.load_req_i && w_load_ready && w_dims_bad;
    end

    assign bus.err_o = r_err;
`else
    assign w_accept  = bus.load_req_i && w_load_ready;
    assign w_m_cap   = M_W'(clamp_dim(32'(bus.load_m_i), MAX_M));
    assign w_n_cap   = N_W'(clamp_dim(32'(bus.load_n_i), MAX_N));
    assign bus.err_o = 1'b0;
`endif

    assign w_xfer = bus.elem_valid_i && w_elem_ready;

    mpu_load_addr_gen #(
        .M_W   (M_W),
        .N_W   (N_W),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept),
        .i_adv   (w_xfer),
        .i_m     (r_m),
        .i_n     (r_n),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = LOAD;
            LOAD:    if (w_xfer && w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_load_ready = 1'b0;
        w_elem_ready = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE:    w_load_ready = 1'b1;
            LOAD: begin
                w_elem_ready = 1'b1;
                w_busy       = 1'b1;
            end
            DONE:    w_done = 1'b1;
            default: w_load_ready = 1'b0;
        endcase
    end

    assign w_idx = IDX_W'(32'(w_row) * 32'(MAX_N) + 32'(w_col));

    // Accepting a request clears the whole register so unwritten slots read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m <= '0;
            r_n <= '0;
            for (int i = 0; i < N_ELEM; i++)
                r_mat[i] <= '0;
        end else if (w_accept) begin
            r_m <= w_m_cap;
            r_n <= w_n_cap;
            for (int i = 0; i < N_ELEM; i++)
                r_mat[i] <= '0;
        end else if (w_xfer) begin
            r_mat[w_idx] <= bus.elem_i;
        end
    end

    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_pack
            assign bus.matrix_o[gi*DATA_W +: DATA_W] = r_mat[gi];
        end
    endgenerate

    assign bus.load_ready_o = w_load_ready;
    assign bus.elem_ready_o = w_elem_ready;
    assign bus.busy_o       = w_busy;
    assign bus.done_o       = w_done;
    assign bus.m_o          = r_m;
    assign bus.n_o          = r_n;

endmodule
`default_nettype wire

// File: tb/tb_mpu_load.sv
`default_nettype none
// ============================================================================
// Module     : tb_mpu_load
// Description: Self-checking bench for mpu_load: table-driven and random
//              loads against a row-major matrix model, plus corner sequences.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mpu_load;
    import mm_defs::*;

    localparam int DW  = FP_BITS;
    localparam int MM  = DEF_MAX_M;
    localparam int MN  = DEF_MAX_N;
    localparam int M_W = $clog2(MM + 1);
    localparam int N_W = $clog2(MN + 1);

    typedef struct {
        int m_req;
        int n_req;
        int exp_m;
        int exp_n;
        int vmode;   // 0 always valid, 1 toggling, 2 random
        int kind;    // 0 fp constants, 1 index ints, 2 random words
        bit mid_req;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];
    float_sp fp_vals [4] = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};

    always #(CLOCK_PERIOD/2) clk = ~clk;

    mpu_load_if #(.DATA_W(DW), .MAX_M(MM), .MAX_N(MN)) bus ();

    mpu_load #(.DATA_W(DW), .MAX_M(MM), .MAX_N(MN)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_matrix(input string tag, input logic [DW-1:0] exp [MM*MN]);
        for (int i = 0; i < MM*MN; i++)
            check($sformatf("%s[%0d][%0d]", tag, i / MN, i % MN), bus.matrix_o[i*DW +: DW], exp[i]);
    endtask

    task automatic run_load(input int m_req, input int n_req, input int exp_m, input int exp_n,
                            input int vmode, input int kind, input bit mid_req);
        logic [DW-1:0] elems[$];
        logic [DW-1:0] exp_mat [MM*MN];
        int  total;
        int  k;
        int  cyc;
        int  early_done;
        int  wait_c;
        bit  v;
        bit  xfer;
        total      = exp_m * exp_n;
        k          = 0;
        cyc        = 0;
        early_done = 0;
        wait_c     = 0;
        while (bus.load_ready_o !== 1'b1 && wait_c < 50) begin
            step();
            wait_c++;
        end
        check("ready_before_req", 64'(bus.load_ready_o), 64'd1);
        bus.load_req_i = 1'b1;
        bus.load_m_i   = M_W'(m_req);
        bus.load_n_i   = N_W'(n_req);
        step();
        bus.load_req_i = 1'b0;
        check("busy_after_accept", 64'(bus.busy_o), 64'd1);
        check("ready_low_in_load", 64'(bus.load_ready_o), 64'd0);
        check("m_captured", 64'(bus.m_o), 64'(exp_m));
        check("n_captured", 64'(bus.n_o), 64'(exp_n));
        check("cleared_on_accept", 64'(bus.matrix_o[(MM*MN-1)*DW +: DW]), 64'd0);
        for (int i = 0; i < total; i++) begin
            if (kind == 0)      elems.push_back(fp_vals[i % 4]);
            else if (kind == 1) elems.push_back(DW'(i));
            else                elems.push_back(DW'($urandom()));
        end
        while (k < total && cyc < 400) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.elem_valid_i = v;
            bus.elem_i       = v ? elems[k] : DW'($urandom());
            if (mid_req && cyc == 2) begin
                bus.load_req_i = 1'b1;
                bus.load_m_i   = M_W'(MM);
                bus.load_n_i   = N_W'(MN);
            end else begin
                bus.load_req_i = 1'b0;
            end
            xfer = v && (bus.elem_ready_o === 1'b1);
            step();
            cyc++;
            if (xfer) k++;
            if (bus.done_o === 1'b1 && k < total) early_done++;
        end
        bus.elem_valid_i = 1'b0;
        bus.load_req_i   = 1'b0;
        check("all_elements_taken", 64'(k), 64'(total));
        check("no_early_done", 64'(early_done), 64'd0);
        check("done_pulse", 64'(bus.done_o), 64'd1);
        check("busy_low_in_done", 64'(bus.busy_o), 64'd0);
        check("elem_ready_low_in_done", 64'(bus.elem_ready_o), 64'd0);
        if (vmode == 0)
            check("latency_cycles", 64'(cyc), 64'(total));
        for (int r = 0; r < MM; r++)
            for (int c = 0; c < MN; c++)
                exp_mat[r*MN + c] = (r < exp_m && c < exp_n) ? elems[r*exp_n + c] : '0;
        check_matrix("matrix", exp_mat);
        check("m_hold", 64'(bus.m_o), 64'(exp_m));
        check("n_hold", 64'(bus.n_o), 64'(exp_n));
        step();
        check("done_one_cycle", 64'(bus.done_o), 64'd0);
        check("ready_after_done", 64'(bus.load_ready_o), 64'd1);
        check_matrix("matrix_held", exp_mat);
    endtask

    initial begin
        #(CLOCK_PERIOD * 50000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] zeros [MM*MN];
        int dones;
        int m_r;
        int n_r;
        foreach (zeros[i]) zeros[i] = '0;

        rst              = 1'b1;
        bus.load_req_i   = 1'b0;
        bus.load_m_i     = '0;
        bus.load_n_i     = '0;
        bus.elem_valid_i = 1'b0;
        bus.elem_i       = '0;
        repeat (3) step();
        check("rst_load_ready", 64'(bus.load_ready_o), 64'd1);
        check("rst_elem_ready", 64'(bus.elem_ready_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_err", 64'(bus.err_o), 64'd0);
        check("rst_m", 64'(bus.m_o), 64'd0);
        check("rst_n", 64'(bus.n_o), 64'd0);
        check_matrix("rst_matrix", zeros);
        rst = 1'b0;
        step();

        vecs.push_back('{2, 2, 2, 2, 0, 0, 1'b0});
        vecs.push_back('{4, 4, 4, 4, 1, 1, 1'b0});
        vecs.push_back('{2, 3, 2, 3, 0, 2, 1'b1});
        vecs.push_back('{1, 1, 1, 1, 0, 2, 1'b0});
        vecs.push_back('{4, 1, 4, 1, 2, 2, 1'b0});
        vecs.push_back('{1, 4, 1, 4, 2, 2, 1'b0});
        vecs.push_back('{3, 2, 3, 2, 1, 2, 1'b0});
        for (int i = 0; i < vecs.size(); i++)
            run_load(vecs[i].m_req, vecs[i].n_req, vecs[i].exp_m, vecs[i].exp_n,
                     vecs[i].vmode, vecs[i].kind, vecs[i].mid_req);

        for (int i = 0; i < 8; i++) begin
            m_r = $urandom_range(1, MM);
            n_r = $urandom_range(1, MN);
            run_load(m_r, n_r, m_r, n_r, $urandom_range(0, 2), 2, 1'b0);
        end

        // Reset in the middle of a 3x3 load discards everything.
        bus.load_req_i = 1'b1;
        bus.load_m_i   = M_W'(3);
        bus.load_n_i   = N_W'(3);
        step();
        bus.load_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.elem_valid_i = 1'b1;
            bus.elem_i       = DW'($urandom()) | 32'h1;
            step();
        end
        bus.elem_valid_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_ready", 64'(bus.load_ready_o), 64'd1);
        check("abort_busy", 64'(bus.busy_o), 64'd0);
        check("abort_m", 64'(bus.m_o), 64'd0);
        check("abort_n", 64'(bus.n_o), 64'd0);
        check_matrix("abort_matrix", zeros);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            bus.elem_valid_i = 1'b1;
            step();
            if (bus.done_o === 1'b1) dones++;
        end
        bus.elem_valid_i = 1'b0;
        check("abort_no_done", 64'(dones), 64'd0);
        check("abort_stays_idle", 64'(bus.busy_o), 64'd0);

`ifdef MPU_LOAD_CHECK_EN
        run_load(2, 2, 2, 2, 0, 1, 1'b0);
        bus.load_req_i = 1'b1;
        bus.load_m_i   = M_W'(0);
        bus.load_n_i   = N_W'(5);
        step();
        bus.load_req_i = 1'b0;
        check("bad_err_pulse", 64'(bus.err_o), 64'd1);
        check("bad_stays_idle", 64'(bus.load_ready_o), 64'd1);
        check("bad_not_busy", 64'(bus.busy_o), 64'd0);
        check("bad_m_unchanged", 64'(bus.m_o), 64'd2);
        check("bad_n_unchanged", 64'(bus.n_o), 64'd2);
        step();
        check("bad_err_one_cycle", 64'(bus.err_o), 64'd0);
        check("bad_still_idle", 64'(bus.busy_o), 64'd0);
`else
        run_load(0, 5, 1, 4, 0, 2, 1'b0);
        run_load(7, 0, 4, 1, 0, 2, 1'b0);
        check("no_err_without_check", 64'(bus.err_o), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
